imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters: the fetch stage (read-only) and the program loader (read/write, burst-capable).
- One access per cycle.
- Fetch has priority; a starvation counter guarantees loader progress.
- A lock FSM lets the loader own the memory for a whole program-load burst.
- Sits between fetch/loader and the memory array; the memory has 1-cycle read latency.

Parameters:
- DEPTH, 256, number of 32-bit words in the memory (power of 2).
- IDX_W, $clog2(DEPTH), width of the memory word index.
- STARVE_MAX, 4, max consecutive denied loader-request cycles before a forced loader grant (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (registered).
- f_rdata  out  32  fetch read data.
- f_err  out  1  fetch address error, qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable.
- l_lock  in  1  loader requests exclusive ownership.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted (combinational).
- l_rvalid  out  1  loader response valid; asserted for reads and writes (write ack).
- l_rdata  out  32  loader read data; 0 for writes.
- l_err  out  1  loader address error, qualified by l_rvalid.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_idx  out  IDX_W  word index = addr[IDX_W+1:2].
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after m_en && !m_we.

Behaviour:
- Reset (async, active-high): state=RUN, starve_cnt=0, f_rvalid=l_rvalid=0, f_err=l_err=0, resp_owner=none. During reset: f_gnt=l_gnt=m_en=m_we=0.
- Address check (combinational): err = addr[1:0]!=0 or addr[31:IDX_W+2]!=0.
  - A granted request with err produces no memory access (m_en=0).
  - Its response still returns next cycle with err=1 and rdata=0.
- FSM states: RUN, LOCKED.
  - RUN arbitration:
    - l_req && (!f_req || starve_cnt==STARVE_MAX) → loader granted.
    - else if f_req → fetch granted.
  - RUN → LOCKED when loader is granted with l_lock=1.
  - In LOCKED: f_gnt=0, and l_gnt=l_req regardless of f_req.
  - LOCKED → RUN on a cycle with l_lock=0 and l_req=0.
  - A granted request in LOCKED with l_lock=0 is served, and the FSM stays LOCKED that cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle l_req && !l_gnt.
  - Clears to 0 on any l_gnt, and whenever l_req=0.
- Memory command: combinational from the granted requester. Fetch: m_we=0.
- Response latency is exactly 1 cycle after grant.
  - resp_owner is registered at grant and routes m_rdata to the f_* or l_* outputs.
  - The other requester's rvalid is 0 that cycle.
- Back-to-back grants every cycle are supported. Throughput is 1 access/cycle.
- Simultaneous f_req and l_req in RUN with starve_cnt<STARVE_MAX: fetch wins, loader waits.
- Requesters must hold req, addr and data until gnt.
- rst asserted mid-burst: the FSM returns to RUN, the lock is dropped, and any pending response is discarded (rvalid=0).

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_fstall[31:0], which counts cycles with f_req && !f_gnt.
  - Adds output perf_lgrant[31:0], which counts loader grants.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Fetch only, f_addr=0x8 with mem[2]=0x00808183 → f_gnt same cycle, m_idx=2; next cycle f_rvalid=1, f_rdata=0x00808183, f_err=0.
- Loader write l_addr=0x10, l_wdata=0xDEADBEEF, then fetch 0x10 → m_we=1, m_idx=4; l_rvalid next cycle; fetch returns 0xDEADBEEF.
- f_req and l_req held high continuously, STARVE_MAX=4 → grants repeat as 4 fetch, 1 loader; starve_cnt returns to 0 after each loader grant.
- Loader l_lock=1, 3 writes, then l_lock=0 with l_req=0, while f_req stays high → f_gnt=0 during the burst and for the release cycle; fetch granted the cycle after.
- Fetch f_addr=0x6 and f_addr=0x400 (DEPTH=256) → m_en=0; f_rvalid=1, f_err=1, f_rdata=0.
- rst pulsed while LOCKED with a read response pending → next cycle l_rvalid=0, state RUN, and a fetch is granted immediately after reset deasserts.

Source files
------------

// File: rtl/imem_arbiter.sv
// Arbiter sharing a single-port instruction memory between fetch (read-only) and the program loader.
// Optional IMEM_ARB_PERF_EN adds fetch-stall and loader-grant performance counters.
module imem_arbiter #(
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  output logic             f_err,
  input  logic             l_req,
  input  logic             l_we,
  input  logic             l_lock,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [31:0]      l_rdata,
  output logic             l_err,
  output logic             m_en,
  output logic             m_we,
  output logic [IDX_W-1:0] m_idx,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic             dbg_locked,
  output logic [3:0]       dbg_starve_cnt
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_fstall,
  output logic [31:0]      perf_lgrant
`endif
);

  // Handshake: a request (req with addr/data) is held until gnt; gnt is combinational and the
  // access completes on that edge. Exactly one cycle later the matching rvalid pulses.
  typedef enum logic {ST_RUN = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  state_t     r_state, w_state_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       w_f_err, w_l_err;
  logic       r_f_rvalid, r_l_rvalid, r_f_err, r_l_err, r_l_we;

  assign w_f_err = (f_addr[1:0] != 2'b00) || (f_addr[31:IDX_W+2] != '0);
  assign w_l_err = (l_addr[1:0] != 2'b00) || (l_addr[31:IDX_W+2] != '0);

  always_comb begin
    w_state_nxt = r_state;
    f_gnt       = 1'b0;
    l_gnt       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (l_req && (!f_req || r_starve == STARVE_LIM)) begin
            l_gnt = 1'b1;
            if (l_lock) w_state_nxt = ST_LOCKED;
          end else if (f_req) begin
            f_gnt = 1'b1;
          end
        end
        ST_LOCKED: begin
          l_gnt = l_req;
          if (!l_lock && !l_req) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!l_req || l_gnt)
      w_starve_nxt = 4'd0;
    else if (r_starve != STARVE_LIM)
      w_starve_nxt = r_starve + 4'd1;
  end

  // Erroneous addresses are granted but never reach the array.
  assign m_en    = (f_gnt && !w_f_err) || (l_gnt && !w_l_err);
  assign m_we    = l_gnt && !w_l_err && l_we;
  assign m_idx   = l_gnt ? l_addr[IDX_W+1:2] : f_addr[IDX_W+1:2];
  assign m_wdata = l_gnt ? l_wdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_starve   <= 4'd0;
      r_f_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_l_err    <= 1'b0;
      r_l_we     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_starve   <= w_starve_nxt;
      r_f_rvalid <= f_gnt;
      r_l_rvalid <= l_gnt;
      r_f_err    <= f_gnt && w_f_err;
      r_l_err    <= l_gnt && w_l_err;
      r_l_we     <= l_gnt && l_we;
    end
  end

  // The registered rvalid bits double as the response owner for routing m_rdata.
  assign f_rvalid = r_f_rvalid;
  assign f_err    = r_f_err;
  assign f_rdata  = (r_f_rvalid && !r_f_err) ? m_rdata : 32'd0;
  assign l_rvalid = r_l_rvalid;
  assign l_err    = r_l_err;
  assign l_rdata  = (r_l_rvalid && !r_l_err && !r_l_we) ? m_rdata : 32'd0;

  assign dbg_locked     = (r_state == ST_LOCKED);
  assign dbg_starve_cnt = r_starve;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] r_perf_fstall, r_perf_lgrant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fstall <= 32'd0;
      r_perf_lgrant <= 32'd0;
    end else begin
      if (f_req && !f_gnt) r_perf_fstall <= r_perf_fstall + 32'd1;
      if (l_gnt)           r_perf_lgrant <= r_perf_lgrant + 32'd1;
    end
  end

  assign perf_fstall = r_perf_fstall;
  assign perf_lgrant = r_perf_lgrant;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_imem_arbiter;

  localparam int DEPTH      = 256;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0]      f_addr = '0, l_addr = '0, l_wdata = '0;
  logic             f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
  logic [31:0]      f_rdata, l_rdata, m_wdata;
  logic [31:0]      m_rdata = '0;
  logic             m_en, m_we, dbg_locked;
  logic [IDX_W-1:0] m_idx;
  logic [3:0]       dbg_starve_cnt;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]      perf_fstall, perf_lgrant;
  logic [31:0]      m_fstall, m_lgrant;
`endif

  imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_idx(m_idx), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dbg_locked(dbg_locked), .dbg_starve_cnt(dbg_starve_cnt)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fstall(perf_fstall), .perf_lgrant(perf_lgrant)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'h0080_8183;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Memory array behind the arbiter: 1-cycle read latency, reloaded during reset.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (m_en) begin
      if (m_we) mem[m_idx] <= m_wdata;
      else      m_rdata    <= mem[m_idx];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          m_locked;
  int          m_starve;
  bit          f_pend, l_pend;
  // Entry: {f_rvalid, f_err, l_rvalid, l_err, rdata}
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_locked = 0;
    m_starve = 0;
    f_pend   = 0;
    l_pend   = 0;
    exp_q.delete();
    exp_q.push_back(36'd0);
`ifdef IMEM_ARB_PERF_EN
    m_fstall = 0;
    m_lgrant = 0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b1;
    #1;
    check("rst_f_gnt",    32'(f_gnt),      32'd0);
    check("rst_l_gnt",    32'(l_gnt),      32'd0);
    check("rst_m_en",     32'(m_en),       32'd0);
    check("rst_m_we",     32'(m_we),       32'd0);
    check("rst_f_rvalid", 32'(f_rvalid),   32'd0);
    check("rst_l_rvalid", 32'(l_rvalid),   32'd0);
    check("rst_locked",   32'(dbg_locked), 32'd0);
    check("rst_starve",   32'(dbg_starve_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                      input logic ll, input logic [31:0] la, input logic [31:0] ld);
    bit          fe, le, fg, lg, en;
    int          fi, li;
    logic [35:0] e;
    logic [31:0] d;
    @(negedge clk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = ll; l_addr = la; l_wdata = ld;
    #1;
    fe = (fa % 4 != 0) || (fa >= 32'(DEPTH * 4));
    le = (la % 4 != 0) || (la >= 32'(DEPTH * 4));
    fi = int'((fa / 4) % DEPTH);
    li = int'((la / 4) % DEPTH);
    if (m_locked) begin
      lg = lr;
      fg = 0;
    end else begin
      lg = lr && (!fr || m_starve == STARVE_MAX);
      fg = fr && !lg;
    end

    // Response for the previous cycle's grant.
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      e = 36'd0;
    end else begin
      e = exp_q.pop_front();
    end
    check("f_rvalid", 32'(f_rvalid), 32'(e[35]));
    check("l_rvalid", 32'(l_rvalid), 32'(e[33]));
    if (e[35]) begin
      check("f_err",   32'(f_err), 32'(e[34]));
      check("f_rdata", f_rdata,    e[31:0]);
    end
    if (e[33]) begin
      check("l_err",   32'(l_err), 32'(e[32]));
      check("l_rdata", l_rdata,    e[31:0]);
    end

    check("locked", 32'(dbg_locked),     32'(m_locked));
    check("starve", 32'(dbg_starve_cnt), 32'(m_starve));
    check("f_gnt",  32'(f_gnt),          32'(fg));
    check("l_gnt",  32'(l_gnt),          32'(lg));
    en = (fg && !fe) || (lg && !le);
    check("m_en", 32'(m_en), 32'(en));
    if (en) begin
      check("m_we",  32'(m_we),  32'(lg && lw));
      check("m_idx", 32'(m_idx), 32'(lg ? li : fi));
      if (lg && lw) check("m_wdata", m_wdata, ld);
    end
`ifdef IMEM_ARB_PERF_EN
    check("perf_fstall", perf_fstall, m_fstall);
    check("perf_lgrant", perf_lgrant, m_lgrant);
    m_fstall += 32'(fr && !fg);
    m_lgrant += 32'(lg);
`endif

    // Advance the model to the next cycle.
    if (fg) begin
      d = fe ? 32'd0 : ref_mem[fi];
      exp_q.push_back({1'b1, fe, 2'b00, d});
    end else if (lg) begin
      d = (le || lw) ? 32'd0 : ref_mem[li];
      if (lw && !le) ref_mem[li] = ld;
      exp_q.push_back({2'b00, 1'b1, le, d});
    end else begin
      exp_q.push_back(36'd0);
    end
    if (!m_locked) m_locked = lg && ll;
    else if (!ll && !lr) m_locked = 0;
    if (!lr || lg) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    f_pend = fr && !fg;
    l_pend = lr && !lg;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      1:       return 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
      default: return 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic        rf, rl, rlw, rll;
  logic [31:0] rfa, rla, rld;

  initial begin
    do_reset();

    // Fetch of mem[2]
    step(1, 32'h8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Loader write then fetch of the same word
    step(0, 0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF);
    step(1, 32'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Both requesters held: starvation counter forces periodic loader grants
    for (int i = 0; i < 12; i++) step(1, 32'h20, 1, 0, 0, 32'h40, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Locked burst of three writes with fetch pending, then release
    step(0, 0,     1, 1, 1, 32'h100, 32'h1111_0001);
    step(1, 32'h0, 1, 1, 1, 32'h104, 32'h1111_0002);
    step(1, 32'h0, 1, 1, 1, 32'h108, 32'h1111_0003);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h104, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Address errors: misaligned and out of range
    step(1, 32'h6,   0, 0, 0, 0, 0);
    step(1, 32'h400, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 32'h3, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset while locked with a loader read response in flight
    step(0, 0, 1, 0, 1, 32'h8, 0);
    do_reset();
    step(1, 32'h8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic honouring the hold-until-grant rule
    rf = 0; rl = 0; rlw = 0; rll = 0; rfa = 0; rla = 0; rld = 0;
    for (int c = 0; c < 400; c++) begin
      if (!f_pend) begin
        rf  = ($urandom_range(0, 3) != 0);
        rfa = rand_addr();
      end
      if (!l_pend) begin
        rl  = ($urandom_range(0, 2) == 0);
        rlw = 1'($urandom_range(0, 1));
        rll = m_locked ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
        rla = rand_addr();
        rld = $urandom;
      end
      step(rf, rfa, rl, rlw, rll, rla, rld);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
